// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Contents: requester count, arbiter FSM state type, ALU select encodings,
// and a helper that turns a requester index into a one-hot vector.
package alu_pkg;

  localparam int unsigned NREQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // ALU select encodings; the arbiter passes select through untouched.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;

  function automatic logic [NREQ-1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter.
// Requests: req_valid/req_ready per requester, packed operands req_a/req_b
// (requester i at [i*WIDTH +: WIDTH]) and req_sel ([i*4 +: 4]).
// Responses: rsp_valid (one-hot or zero), rsp_ready per requester, and the
// shared held result rsp_out/rsp_cout/rsp_z.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [7:0]         req_sel;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_out;
  logic               rsp_cout;
  logic               rsp_z;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_cout, rsp_z
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_cout, rsp_z
  );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Two-way round-robin grant selection.
// Ports: valid[1:0] request vector, last_grant index of the previous winner,
// grant[1:0] one-hot winner (zero when nothing is valid).
module rr_pick
  import alu_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic            last_grant,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (&valid) begin
      // Contention: favour whichever requester did not win last time.
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU.
// Ports: clk, rst_n (async, active-low); bus (alu_arbiter_if.slave) carrying
// request/response handshakes; alu_a/alu_b/alu_sel drive the external ALU,
// alu_out/alu_cout/alu_z return its result; done_cnt holds a 16-bit
// completed-operation counter per requester ([i*16 +: 16]).
// Flow: IDLE grants one requester, EXEC waits one cycle for the ALU, RESP
// holds the result until its owner consumes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = alu_pkg::NREQ
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_arbiter_if.slave       bus,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_sel,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_cout,
  input  logic               alu_z,
  output logic [2*16-1:0]    done_cnt
);

  state_t           state_q;
  logic             id_q;
  logic             last_grant_q;
  logic [NREQ-1:0]  grant;
  logic [WIDTH-1:0] rsp_out_q;
  logic             rsp_cout_q;
  logic             rsp_z_q;
  logic [15:0]      cnt0_q;
  logic [15:0]      cnt1_q;
  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;
  logic [3:0]       pick_sel;

  rr_pick u_rr_pick (
    .valid      (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // rst_n gates req_ready so no handshake is offered while reset is held.
  assign bus.req_ready = (rst_n && (state_q == ST_IDLE)) ? grant : '0;
  assign bus.rsp_valid = (state_q == ST_RESP) ? id_onehot(id_q) : '0;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_z     = rsp_z_q;
  assign done_cnt      = {cnt1_q, cnt0_q};

  always_comb begin
    pick_a   = bus.req_a[0 +: WIDTH];
    pick_b   = bus.req_b[0 +: WIDTH];
    pick_sel = bus.req_sel[0 +: 4];
    if (grant[1]) begin
      pick_a   = bus.req_a[WIDTH +: WIDTH];
      pick_b   = bus.req_b[WIDTH +: WIDTH];
      pick_sel = bus.req_sel[4 +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
      rsp_out_q    <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_z_q      <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            id_q         <= grant[1];
            last_grant_q <= grant[1];
            alu_a        <= pick_a;
            alu_b        <= pick_b;
            alu_sel      <= pick_sel;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_out_q  <= alu_out;
          rsp_cout_q <= alu_cout;
          rsp_z_q    <= alu_z;
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready[id_q]) begin
            if (id_q) cnt1_q <= cnt1_q + 16'd1;
            else      cnt0_q <= cnt0_q + 16'd1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
